// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot-session controller.
// Holds the FSM state encoding, default sizing constants and the
// saturating increment used by the tally and total counters.
package vote_pkg;

  localparam int NUM_CAND_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COMMIT,
    ST_LOCKOUT,
    ST_RESULT
  } vote_state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/vote_priority_arb.sv
// Fixed-priority encoder over the candidate vote pulses.
// The lowest set index wins; any_hit flags that at least one bit is set.
// Kept separate so a rotating-priority variant can drop in later.
module vote_priority_arb
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic [NUM_CAND-1:0] req,
  output logic                any_hit,
  output logic [IDX_W-1:0]    idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any_hit = |req;
    idx     = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot-session controller: opens one ballot per officer arm, commits a
// single vote per ballot into saturating per-candidate tallies, holds a
// lockout after every vote and serves a registered result readout.
// Optional feature macro: VOTE_ARM_TIMEOUT_EN (ARMED-state timeout).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for arm (ballot) or mode=1 (readout)
// ST_ARMED   | ballot open, ready=1, waiting for a candidate pulse
// ST_COMMIT  | one cycle, accepted=1, winner's tally and total update
// ST_LOCKOUT | busy=1 for LOCK_CYCLES cycles, all inputs ignored
// ST_RESULT  | rd_count follows tally[rd_sel] with one cycle latency
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_CAND    = NUM_CAND_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_CYCLES = 100,
  parameter int ARM_TIMEOUT = 1000,
  parameter int SEL_W       = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic                ready,
  output logic                accepted,
  output logic [SEL_W-1:0]    accepted_idx,
  output logic                busy,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    total_votes,
  output logic                sat_flag,
  output logic                timeout
);

  localparam int               LT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LT_W-1:0]  LOCK_LOAD = LT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  vote_state_t      state;
  logic [CNT_W-1:0] tally [NUM_CAND];
  logic [LT_W-1:0]  lock_tmr;
  logic             any_hit;
  logic [SEL_W-1:0] hit_idx;
  logic [CNT_W-1:0] tally_inc;
  logic [CNT_W-1:0] total_inc;
  logic             rd_in_range;
  logic [CNT_W-1:0] rd_value;

`ifdef VOTE_ARM_TIMEOUT_EN
  localparam int              AT_W    = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [AT_W-1:0] AT_LOAD = AT_W'(ARM_TIMEOUT - 1);
  logic [AT_W-1:0] arm_tmr;
`else
  // Without the feature a ballot waits forever; ARM_TIMEOUT is never
  // negative, so this folds to a constant 0.
  assign timeout = (ARM_TIMEOUT < 0);
`endif

  vote_priority_arb #(
    .NUM_CAND (NUM_CAND),
    .IDX_W    (SEL_W)
  ) u_arb (
    .req     (valid_vote),
    .any_hit (any_hit),
    .idx     (hit_idx)
  );

  // Next counter values for the committed candidate and the readout mux.
  always_comb begin
    tally_inc   = CNT_W'(sat_inc(32'(tally[accepted_idx]), 32'(CNT_MAX)));
    total_inc   = CNT_W'(sat_inc(32'(total_votes), 32'(CNT_MAX)));
    rd_in_range = ({1'b0, rd_sel} < NUM_CAND[SEL_W:0]);
    rd_value    = rd_in_range ? tally[rd_sel] : '0;
  end

  // Session FSM with registered outputs, tallies and the lockout timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      ready        <= 1'b0;
      accepted     <= 1'b0;
      accepted_idx <= '0;
      busy         <= 1'b0;
      rd_count     <= '0;
      total_votes  <= '0;
      sat_flag     <= 1'b0;
      lock_tmr     <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
`ifdef VOTE_ARM_TIMEOUT_EN
      timeout      <= 1'b0;
      arm_tmr      <= '0;
`endif
    end else begin
      accepted <= 1'b0;
`ifdef VOTE_ARM_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          rd_count <= '0;
          if (mode) begin
            state    <= ST_RESULT;
            rd_count <= rd_value;
          end else if (arm) begin
            state <= ST_ARMED;
            ready <= 1'b1;
`ifdef VOTE_ARM_TIMEOUT_EN
            arm_tmr <= AT_LOAD;
`endif
          end
        end

        ST_ARMED: begin
          if (any_hit) begin
            state        <= ST_COMMIT;
            ready        <= 1'b0;
            accepted     <= 1'b1;
            accepted_idx <= hit_idx;
            busy         <= 1'b1;
          end
`ifdef VOTE_ARM_TIMEOUT_EN
          else if (arm_tmr == '0) begin
            state   <= ST_IDLE;
            ready   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            arm_tmr <= arm_tmr - AT_W'(1);
          end
`endif
        end

        ST_COMMIT: begin
          tally[accepted_idx] <= tally_inc;
          total_votes         <= total_inc;
          if ((tally_inc == CNT_MAX) || (total_inc == CNT_MAX)) sat_flag <= 1'b1;
          lock_tmr <= LOCK_LOAD;
          state    <= ST_LOCKOUT;
        end

        ST_LOCKOUT: begin
          if (lock_tmr == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            lock_tmr <= lock_tmr - LT_W'(1);
          end
        end

        ST_RESULT: begin
          if (!mode) begin
            state    <= ST_IDLE;
            rd_count <= '0;
          end else begin
            rd_count <= rd_value;
          end
        end

        default: begin
          state    <= ST_IDLE;
          ready    <= 1'b0;
          busy     <= 1'b0;
          rd_count <= '0;
        end
      endcase
    end
  end

endmodule
